lsu_rmw: RTL
============

# lsu_rmw

Load/store unit between the MEM-stage pipeline register and the word-only data memory (Dmem). It converts byte, halfword and word loads and stores into Dmem word accesses. Sub-word stores are performed as a two-cycle read-modify-write, with a stall to the pipeline. Loaded data is registered, aligned, and sign- or zero-extended for write-back.

## Interface
Parameters:
- AW, 16, byte-address width; the Dmem word address is AW-2 = 14 bits.
- DW, 32, data width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as misaligned).
- load_unsigned  in  1  1 = zero-extend sub-word loads; 0 = sign-extend.
- addr  in  AW  byte address.
- write_data  in  DW  store data, right-justified.
- stall  out  1  upstream must hold its request and freeze.
- load_data  out  DW  aligned, extended load result.
- load_valid  out  1  one-cycle pulse; load_data is valid.
- misalign  out  1  one-cycle pulse; the request was rejected.
- dmem_addr  out  AW-2  Dmem word address.
- dmem_write_data  out  DW  Dmem write data.
- dmem_MemRead  out  1  Dmem read strobe.
- dmem_MemWrite  out  1  Dmem write strobe.
- dmem_read_data  in  DW  Dmem read data, combinational from dmem_addr.

## Operation
- Byte lanes are little-endian: byte offset k maps to bits 8k+7:8k. A halfword at offset 0 uses bits 15:0; at offset 2 it uses bits 31:16.
- A request is present when exactly one of MemRead/MemWrite is high in IDLE. With both high: no Dmem access, misalign pulses.
- A request is misaligned when size=01 with addr[0]=1, size=10 with addr[1:0]≠0, or size=11. A misaligned request makes no Dmem access and misalign pulses the next cycle.
- FSM states and transitions:
  - IDLE → RMW_WR on a sub-word store. IDLE stays IDLE otherwise.
  - RMW_WR → IDLE unconditionally.
- IDLE, load:
  - dmem_MemRead=1 and dmem_addr=addr[AW-1:2].
  - At the clock edge, the selected lane is extended into load_data and load_valid pulses.
- IDLE, word store: dmem_MemWrite=1 and dmem_write_data=write_data, in a single cycle.
- IDLE, sub-word store:
  - dmem_MemRead=1 and stall=1.
  - At the clock edge, latch the read word, word address, offset, size and write_data.
- RMW_WR:
  - dmem_MemWrite=1, using the latched word with the target lane(s) replaced by the low byte or half of the latched write_data.
  - stall=0. Request inputs are ignored in this cycle, because they still hold the same stalled store.
- Dmem strobes are 0 whenever no access is in progress.

## Timing
- Reset values: state=IDLE, load_data=0, load_valid=0, misalign=0, stall=0, all latches 0. All dmem_* strobes are forced to 0 while rst is high.
- Load latency: 1 cycle, request cycle to load_valid. Loads never stall.
- Word store: 1 cycle, no stall.
- Sub-word store: 2 cycles, with stall high in the first cycle only.
- Back-to-back: a new request is accepted in the first IDLE cycle after RMW_WR.
- load_data holds its value until the next load completes.
- Reset asserted during RMW_WR: the write is abandoned and Dmem is unmodified. The FSM returns to IDLE asynchronously.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misalignment is detected and rejected as described above.
- LSU_MISALIGN_TRAP_EN undefined:
  - misalign is tied to 0.
  - Low address bits are masked: addr[0] is ignored for halves, addr[1:0] for words.
  - size=11 is treated as a word access.
  - The both-strobes case is still suppressed, with no pulse.

## Structure
- Package mips_mem_pkg holds:
  - the size encodings SZ_BYTE, SZ_HALF and SZ_WORD;
  - the lsu_state_t enum {IDLE, RMW_WR};
  - the DMEM_AW=14 constant.
- Sub-module lsu_align is combinational and holds two functions: load lane select/extend, and store lane merge. It is shared by the load and RMW paths.

## Test plan
- Word store 0xDEADBEEF at addr 0x0010, then word load from 0x0010 → load_valid one cycle later with load_data=0xDEADBEEF. stall stays 0 throughout.
- Byte store 0x5A at 0x0011 over the word 0xDEADBEEF → stall high for 1 cycle, then Dmem word 0xDEAD5AEF.
- Load byte 0x0013 with signed, then unsigned → 0xFFFFFFDE, then 0x000000DE.
- Half store 0x1234 at 0x0012 → word 0x12345AEF. Signed half load at 0x0012 → 0x00001234.
- Half load at 0x0011 with the trap enabled → misalign pulses, no Dmem strobe, load_valid stays 0. Same with the trap disabled → data from offset 0, i.e. 0x00005AEF.
- rst asserted mid-RMW_WR during byte store 0xFF at 0x0010 → all outputs 0 immediately. A subsequent word load from 0x0010 returns 0x12345AEF, unchanged.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared definitions for the load/store unit.
//   - access size encodings (SZ_BYTE, SZ_HALF, SZ_WORD; 2'b11 is reserved)
//   - lsu_state_t, the read-modify-write FSM states
//   - DMEM_AW, the Dmem word-address width
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int DMEM_AW = 14;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane helpers shared by the load and RMW paths.
// Lanes are little-endian: byte offset k occupies bits 8k+7:8k.
// Ports:
//   ld_word/ld_off/ld_size/ld_unsigned -> ld_data   : lane select + sign/zero extend
//   st_word/st_off/st_size/st_data     -> st_merged : replace target lane(s) with
//                                                     the low byte/half of st_data
module lsu_align
    import mips_mem_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] ld_word,
    input  logic [1:0]    ld_off,
    input  logic [1:0]    ld_size,
    input  logic          ld_unsigned,
    output logic [DW-1:0] ld_data,
    input  logic [DW-1:0] st_word,
    input  logic [1:0]    st_off,
    input  logic [1:0]    st_size,
    input  logic [DW-1:0] st_data,
    output logic [DW-1:0] st_merged
);

    function automatic logic [DW-1:0] load_extend(input logic [DW-1:0] word,
                                                  input logic [1:0] off,
                                                  input logic [1:0] sz,
                                                  input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [DW-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_BYTE: r = {{24{~uns & b[7]}}, b};
            SZ_HALF: r = {{16{~uns & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [DW-1:0] store_merge(input logic [DW-1:0] word,
                                                  input logic [1:0] off,
                                                  input logic [1:0] sz,
                                                  input logic [DW-1:0] data);
        logic [DW-1:0] r;
        r = word;
        case (sz)
            SZ_BYTE: r[{off, 3'b000} +: 8] = data[7:0];
            SZ_HALF: begin
                if (off[1]) r[31:16] = data[15:0];
                else        r[15:0]  = data[15:0];
            end
            default: r = data;
        endcase
        return r;
    endfunction

    assign ld_data   = load_extend(ld_word, ld_off, ld_size, ld_unsigned);
    assign st_merged = store_merge(st_word, st_off, st_size, st_data);

endmodule

// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit between the MEM pipeline register and a word-only Dmem.
// Byte/half/word loads complete in one cycle (registered, aligned, extended).
// Word stores write directly; sub-word stores do a two-cycle read-modify-write
// with stall high in the read cycle.
// Build option: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned requests and both-strobe requests are rejected and
//               misalign pulses the following cycle.
//   undefined - misalign is 0, low address bits are masked, size 11 acts as word,
//               both-strobe requests are silently dropped.
// Ports:
//   clk, rst (async, active high)
//   MemRead, MemWrite, size, load_unsigned, addr, write_data : request
//   stall, load_data, load_valid, misalign                   : to pipeline
//   dmem_addr, dmem_write_data, dmem_MemRead, dmem_MemWrite  : to Dmem
//   dmem_read_data                                           : from Dmem (comb)
module lsu_rmw
    import mips_mem_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [1:0]    size,
    input  logic          load_unsigned,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] write_data,
    output logic          stall,
    output logic [DW-1:0] load_data,
    output logic          load_valid,
    output logic          misalign,
    output logic [AW-3:0] dmem_addr,
    output logic [DW-1:0] dmem_write_data,
    output logic          dmem_MemRead,
    output logic          dmem_MemWrite,
    input  logic [DW-1:0] dmem_read_data
);

    lsu_state_t    state, next_state;

    logic [AW-3:0] lat_addr;
    logic [1:0]    lat_off;
    logic [1:0]    lat_size;
    logic [DW-1:0] lat_word;
    logic [DW-1:0] lat_wdata;

    logic          rd_req, wr_req, both_req, idle;
    logic [1:0]    eff_size, eff_off;
    logic          bad, misalign_next;
    logic          do_load, do_wstore, do_sstore;
    logic [DW-1:0] ld_data, st_merged;

    assign rd_req   = MemRead & ~MemWrite;
    assign wr_req   = MemWrite & ~MemRead;
    assign both_req = MemRead & MemWrite;
    assign idle     = (state == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    assign eff_size = size;
    assign eff_off  = addr[1:0];
    always_comb begin
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr[0];
            SZ_WORD: bad = |addr[1:0];
            default: bad = 1'b1;
        endcase
    end
    assign misalign_next = idle & (both_req | ((rd_req | wr_req) & bad));
`else
    // Reserved size folds into word; offsets are forced to the natural boundary.
    assign eff_size = (size == 2'b11) ? SZ_WORD : size;
    always_comb begin
        case (eff_size)
            SZ_BYTE: eff_off = addr[1:0];
            SZ_HALF: eff_off = {addr[1], 1'b0};
            default: eff_off = 2'b00;
        endcase
    end
    assign bad           = 1'b0;
    assign misalign_next = 1'b0;
`endif

    assign do_load   = idle & rd_req & ~bad;
    assign do_wstore = idle & wr_req & ~bad & (eff_size == SZ_WORD);
    assign do_sstore = idle & wr_req & ~bad & (eff_size != SZ_WORD);

    lsu_align #(.DW(DW)) u_align (
        .ld_word     (dmem_read_data),
        .ld_off      (eff_off),
        .ld_size     (eff_size),
        .ld_unsigned (load_unsigned),
        .ld_data     (ld_data),
        .st_word     (lat_word),
        .st_off      (lat_off),
        .st_size     (lat_size),
        .st_data     (lat_wdata),
        .st_merged   (st_merged)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next state
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (do_sstore) next_state = RMW_WR;
            RMW_WR:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs; everything is held low during reset so an interrupted RMW
    // write never reaches Dmem.
    always_comb begin
        stall           = 1'b0;
        dmem_addr       = '0;
        dmem_write_data = '0;
        dmem_MemRead    = 1'b0;
        dmem_MemWrite   = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    dmem_addr       = addr[AW-1:2];
                    dmem_write_data = write_data;
                    dmem_MemRead    = do_load | do_sstore;
                    dmem_MemWrite   = do_wstore;
                    stall           = do_sstore;
                end
                RMW_WR: begin
                    // Request inputs still show the stalled store; ignore them.
                    dmem_addr       = lat_addr;
                    dmem_write_data = st_merged;
                    dmem_MemWrite   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Load result, pulses, and RMW latches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_data  <= '0;
            load_valid <= 1'b0;
            misalign   <= 1'b0;
            lat_addr   <= '0;
            lat_off    <= '0;
            lat_size   <= '0;
            lat_word   <= '0;
            lat_wdata  <= '0;
        end else begin
            load_valid <= do_load;
            misalign   <= misalign_next;
            if (do_load) load_data <= ld_data;
            if (do_sstore) begin
                lat_addr  <= addr[AW-1:2];
                lat_off   <= eff_off;
                lat_size  <= eff_size;
                lat_word  <= dmem_read_data;
                lat_wdata <= write_data;
            end
        end
    end

endmodule
